fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of the opcode decoder. It owns the program counter and issues requests to the instruction memory with a ready handshake. It registers each returned instruction into the IF/ID pipeline register and presents `if_id_opcode` to the decoder. It handles ID-stage stalls with a one-entry skid buffer, and branch/JAL redirects with a flush.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `XLEN`, default 32: address and instruction width; only 32 is supported.

Clocking: one clock; reset is asynchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  XLEN  fetch address; always equals the current PC.
- `imem_rdata`  in  XLEN  instruction word; valid only when `imem_ready`=1.
- `imem_ready`  in  1  memory returns `imem_rdata` for the current `imem_addr` this cycle.
- `stall`  in  1  ID stage cannot accept; the IF/ID register holds.
- `redirect`  in  1  branch taken or JAL, resolved downstream.
- `redirect_pc`  in  XLEN  target address; bits [1:0] ignored and treated as 0.
- `if_id_valid`  out  1  IF/ID holds a live instruction.
- `if_id_pc`  out  XLEN  PC of the IF/ID instruction.
- `if_id_inst`  out  XLEN  IF/ID instruction word.
- `if_id_opcode`  out  7  `if_id_inst[6:0]` when `if_id_valid`=1, else 7'b0 (bubble; the decoder accepts 0 as a legal no-op).

## Operation

- States:
  - BOOT: `imem_req`=0.
  - FETCH: `imem_req`=1.
  - HELD: `imem_req`=0; the skid buffer is full.
- BOOT → FETCH unconditionally after one cycle.
- Priority each cycle: `rst` > `redirect` > `imem_ready`/`stall` logic.
- Redirect, in any state:
  - `pc` ← {`redirect_pc[31:2]`, 2'b00}.
  - `if_id_valid` ← 0 and skid buffer cleared.
  - State → FETCH.
  - A coincident `imem_ready` response is discarded.
  - The memory tolerates abandoned requests and address changes while `imem_req`=1.
- FETCH, `imem_ready`=1, `stall`=0: IF/ID ← {valid=1, pc, `imem_rdata`}; `pc` ← `pc`+4.
- FETCH, `imem_ready`=1, `stall`=1: skid ← {pc, `imem_rdata`}; `pc` ← `pc`+4; IF/ID unchanged; state → HELD.
- FETCH, `imem_ready`=0, `stall`=0: `if_id_valid` ← 0 (bubble); `pc` holds.
- FETCH, `imem_ready`=0, `stall`=1: IF/ID unchanged; `pc` holds.
- HELD, `stall`=1: all state holds.
- HELD, `stall`=0: IF/ID ← skid with valid=1; state → FETCH. No request is made this cycle.
- Arithmetic: `pc`+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). No misalignment trap.
- `stall` holds IF/ID even when `if_id_valid`=0.

## Timing

- Reset values, applied asynchronously:
  - `pc`=`RESET_PC` and state=BOOT.
  - `imem_req`=0 and `imem_addr`=`RESET_PC`.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_inst`=0, `if_id_opcode`=0.
  - Skid buffer empty.
- First `imem_req`=1 occurs in the 2nd rising-edge cycle after `rst` falls (one BOOT cycle).
- `imem_req` and `imem_addr` come combinationally from registered state, with no input-to-output paths.
- Latency: the instruction appears on IF/ID the edge after `imem_ready`.
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- Redirect penalty: the first target instruction reaches IF/ID at the earliest one cycle after the redirect edge plus memory latency. The IF/ID contents in the redirect cycle are killed at that edge.
- Reset asserted mid-request: the request is dropped immediately (`imem_req`=0 asynchronously). No state survives.
- Stall released in HELD: `imem_req` rises one cycle later, so there is one bubble-free handoff and then resumed fetch.

## Test plan

- Reset with `RESET_PC`=32'h100 and `imem_ready` tied 1:
  - `imem_req` rises one cycle after reset release.
  - `if_id_pc` sequence is 0x100, 0x104, 0x108; `if_id_opcode` matches `inst[6:0]`.
- Wait states, `imem_ready` high every 3rd cycle:
  - `if_id_valid` pulses once per 3 cycles, opcode 0 in between.
  - `imem_addr` stable until ready.
- Stall 4 cycles while `imem_ready`=1:
  - IF/ID holds the 0x104 instruction and the skid captures 0x108.
  - On release, 0x108 enters IF/ID; no instruction is lost or duplicated.
- Redirect to 32'h2003 coincident with `imem_ready` and `stall`=1:
  - Response discarded, `if_id_valid`=0 next cycle, skid cleared.
  - Next `imem_addr`=0x2000.
- PC wrap, redirect to 32'hFFFF_FFFC: next fetch address is 0x0000_0000.
- Assert `rst` mid-FETCH with `imem_ready`=0: all outputs immediately take their reset values; the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests, fills the
// IF/ID pipeline register, absorbs one ID stall with a skid entry, and
// flushes on branch/JAL redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_inst,
    output logic [6:0]      if_id_opcode
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [XLEN-1:0] skid_inst_q;
    logic            if_id_valid_q;
    logic [XLEN-1:0] if_id_pc_q;
    logic [XLEN-1:0] if_id_inst_q;
    logic [XLEN-1:0] pc_plus4_s;
    logic            unused_rpc_lsb_s;

    // Target alignment drops the low two bits of the redirect address.
    assign unused_rpc_lsb_s = ^redirect_pc[1:0];
    assign pc_plus4_s       = pc_q + XLEN'(4);

    // Fetch FSM: redirect outranks everything; HELD means the skid entry is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC[XLEN-1:0];
            skid_pc_q     <= {XLEN{1'b0}};
            skid_inst_q   <= {XLEN{1'b0}};
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= {XLEN{1'b0}};
            if_id_inst_q  <= {XLEN{1'b0}};
        end else if (redirect) begin
            // Kill IF/ID and the skid entry; any coincident response is dropped.
            state_q       <= FETCH;
            pc_q          <= {redirect_pc[XLEN-1:2], 2'b00};
            skid_pc_q     <= {XLEN{1'b0}};
            skid_inst_q   <= {XLEN{1'b0}};
            if_id_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        pc_q <= pc_plus4_s;
                        if (stall) begin
                            // ID is busy: park the response instead of losing it.
                            skid_pc_q   <= pc_q;
                            skid_inst_q <= imem_rdata;
                            state_q     <= HELD;
                        end else begin
                            if_id_valid_q <= 1'b1;
                            if_id_pc_q    <= pc_q;
                            if_id_inst_q  <= imem_rdata;
                        end
                    end else if (!stall) begin
                        if_id_valid_q <= 1'b0;
                    end else begin
                        if_id_valid_q <= if_id_valid_q;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        // Hand the parked instruction to ID; no request this cycle.
                        if_id_valid_q <= 1'b1;
                        if_id_pc_q    <= skid_pc_q;
                        if_id_inst_q  <= skid_inst_q;
                        state_q       <= FETCH;
                    end else begin
                        state_q <= HELD;
                    end
                end
                default: begin
                    state_q       <= BOOT;
                    if_id_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Request and address derive only from registered state.
    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign if_id_valid  = if_id_valid_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_inst   = if_id_inst_q;
    // A bubble presents opcode 0, which the decoder treats as a no-op.
    assign if_id_opcode = if_id_valid_q ? if_id_inst_q[6:0] : 7'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table for the
// reset/stream/stall sequence, hand-written corner sequences, and a random
// phase, all checked by a scoreboard of expected IF/ID entries.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic [6:0]  if_id_opcode;

    fetch_unit #(.RESET_PC(32'h0000_0100), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_inst(if_id_inst), .if_id_opcode(if_id_opcode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        rdy;
        logic        st;
        logic        x_req;
        logic [31:0] x_addr;
        logic        x_valid;
        logic [31:0] x_pc;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    ent_t sb_q[$];
    ent_t cur;
    logic cur_valid;
    logic [31:0] exp_pc;
    bit   boot;
    logic obs_req;
    logic [31:0] obs_addr;
    vec_t vecs[10];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[13:0], 2'b11};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        cur.pc    = 32'h0;
        cur.inst  = 32'h0;
        cur_valid = 1'b0;
        exp_pc    = 32'h0000_0100;
        boot      = 1'b1;
    endtask

    // One clock cycle: entered just after a falling edge, leaves after the next one.
    task automatic cyc(input logic rdy, input logic st, input logic rd, input logic [31:0] rpc);
        ent_t e;
        imem_ready  = rdy;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        imem_rdata  = rdy ? inst_of(imem_addr) : 32'hDEAD_BEEF;
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        chk("imem_req", {31'b0, imem_req}, {31'b0, (!boot && sb_q.size() == 0)});
        chk("imem_addr", imem_addr, exp_pc);
        if (rd) begin
            sb_q.delete();
            exp_pc    = {rpc[31:2], 2'b00};
            cur_valid = 1'b0;
            boot      = 1'b0;
        end else if (boot) begin
            boot = 1'b0;
        end else if (sb_q.size() != 0) begin
            if (!st) begin
                cur       = sb_q.pop_front();
                cur_valid = 1'b1;
            end
        end else if (rdy) begin
            e.pc   = exp_pc;
            e.inst = inst_of(exp_pc);
            sb_q.push_back(e);
            exp_pc = exp_pc + 32'd4;
            if (!st) begin
                cur       = sb_q.pop_front();
                cur_valid = 1'b1;
            end
        end else if (!st) begin
            cur_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, cur_valid});
        chk("if_id_opcode", {25'b0, if_id_opcode}, cur_valid ? {25'b0, cur.inst[6:0]} : 32'h0);
        if (cur_valid) begin
            chk("if_id_pc", if_id_pc, cur.pc);
            chk("if_id_inst", if_id_inst, cur.inst);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},    {31'b0, imem_req},    32'h0);
        chk({tag, "_addr"},   imem_addr,            32'h0000_0100);
        chk({tag, "_valid"},  {31'b0, if_id_valid}, 32'h0);
        chk({tag, "_pc"},     if_id_pc,             32'h0);
        chk({tag, "_inst"},   if_id_inst,           32'h0);
        chk({tag, "_opcode"}, {25'b0, if_id_opcode}, 32'h0);
    endtask

    initial begin
        // rdy st | req addr | valid if_id_pc (after edge)
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h104, 1'b1, 32'h104};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h10C, 1'b1, 32'h104};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h10C, 1'b1, 32'h104};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h10C, 1'b1, 32'h104};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h10C, 1'b1, 32'h108};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h10C};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 32'h110, 1'b1, 32'h110};

        rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Reset release, zero-wait stream, 4-cycle stall with skid capture.
        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].rdy, vecs[i].st, 1'b0, 32'h0);
            chk("tbl_req",   {31'b0, obs_req},     {31'b0, vecs[i].x_req});
            chk("tbl_addr",  obs_addr,             vecs[i].x_addr);
            chk("tbl_valid", {31'b0, if_id_valid}, {31'b0, vecs[i].x_valid});
            if (vecs[i].x_valid)
                chk("tbl_pc", if_id_pc, vecs[i].x_pc);
        end

        // Wait states: ready every third cycle.
        for (int i = 0; i < 9; i++)
            cyc((i % 3) == 2, 1'b0, 1'b0, 32'h0);

        // Fill the skid, then redirect with ready and stall both high.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_2003);
        chk("redir_killed", {31'b0, if_id_valid}, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);

        // Stall with an empty IF/ID keeps the bubble.
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset mid-FETCH with the memory not ready.
        imem_ready = 1'b0; stall = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
